uart_rx_deframer: RTL and testbench

//  UART receive deframer fed by the debounced serial line from the RX input filter.

---
 rtl/uart_rx_deframer_if.sv | 37 +++
 rtl/uart_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// Interface: uart_rx_deframer_if
// Groups the deframer's serial input, line configuration and received-word status.
//   rxclk      : 1/OVS bit-time clock enable
//   clear      : synchronous abort
//   wls        : word length select (00=5 .. 11=8 bits)
//   pen/eps/sp : parity enable, even parity select, stick parity
//   sin        : filtered serial input, idle high
//   dout       : received word, unused MSBs zero
//   pe/fe/bi   : parity error, framing error, break
//   rxfinished : one-cycle strobe, dout/pe/fe/bi updated
// master drives line and config (bench / line filter), slave is the deframer.
interface uart_rx_deframer_if #(
  parameter int unsigned DWIDTH = 8
);
  logic              rxclk;
  logic              clear;
  logic [1:0]        wls;
  logic              pen;
  logic              eps;
  logic              sp;
  logic              sin;
  logic [DWIDTH-1:0] dout;
  logic              pe;
  logic              fe;
  logic              bi;
  logic              rxfinished;

  modport master (
    output rxclk, clear, wls, pen, eps, sp, sin,
    input  dout, pe, fe, bi, rxfinished
  );

  modport slave (
    input  rxclk, clear, wls, pen, eps, sp, sin,
    output dout, pe, fe, bi, rxfinished
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// Module: uart_rx_deframer
// UART receive deframer. Oversamples the filtered serial line at OVS x baud (rxclk enable),
// validates the start bit at its centre, shifts in 5-8 data bits LSB-first, checks optional
// parity and the first stop bit, and presents the word with PE/FE/BI and a one-cycle strobe.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_deframer_if.slave (rxclk, clear, config, sin in; dout/status out)
module uart_rx_deframer #(
  parameter int unsigned OVS    = 16,
  parameter int unsigned DWIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  uart_rx_deframer_if.slave bus
);
  localparam int unsigned CW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [CW-1:0] HalfCnt = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LastCnt = CW'(OVS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StMwait} state_e;

  state_e            state_q;
  logic [CW-1:0]     ovs_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [DWIDTH-1:0] data_q;
  logic [1:0]        wls_q;
  logic              pen_q, eps_q, sp_q;
  logic              par_q;     // sampled parity bit
  logic              perr_q;    // parity mismatch, reported at stop
  logic [DWIDTH-1:0] dout_q;
  logic              pe_q, fe_q, bi_q, rxfinished_q;

  logic       sample;
  logic       exp_par;
  logic [2:0] last_bit;

  // One sample per bit at its centre; the start state already aligned the counter.
  assign sample   = (ovs_cnt_q == LastCnt);
  // Unused upper data bits are zero, so a full-width reduction gives the word parity.
  assign exp_par  = sp_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);
  assign last_bit = {1'b0, wls_q} + 3'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ovs_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      wls_q        <= '0;
      pen_q        <= 1'b0;
      eps_q        <= 1'b0;
      sp_q         <= 1'b0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      bi_q         <= 1'b0;
      rxfinished_q <= 1'b0;
    end else begin
      rxfinished_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= StIdle;
        ovs_cnt_q <= '0;
        bit_cnt_q <= '0;
        data_q    <= '0;
        par_q     <= 1'b0;
        perr_q    <= 1'b0;
        dout_q    <= '0;
        pe_q      <= 1'b0;
        fe_q      <= 1'b0;
        bi_q      <= 1'b0;
      end else if (bus.rxclk) begin
        unique case (state_q)
          StIdle: begin
            if (!bus.sin) begin
              state_q   <= StStart;
              ovs_cnt_q <= '0;
            end
          end
          StStart: begin
            if (ovs_cnt_q == HalfCnt) begin
              ovs_cnt_q <= '0;
              if (!bus.sin) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
                data_q    <= '0;
                par_q     <= 1'b0;
                perr_q    <= 1'b0;
                wls_q     <= bus.wls;
                pen_q     <= bus.pen;
                eps_q     <= bus.eps;
                sp_q      <= bus.sp;
              end else begin
                state_q <= StIdle;  // glitch, not a real start bit
              end
            end else begin
              ovs_cnt_q <= ovs_cnt_q + 1'b1;
            end
          end
          StData: begin
            if (sample) begin
              ovs_cnt_q         <= '0;
              data_q[bit_cnt_q] <= bus.sin;
              if (bit_cnt_q == last_bit) begin
                bit_cnt_q <= '0;
                state_q   <= pen_q ? StPar : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              ovs_cnt_q <= ovs_cnt_q + 1'b1;
            end
          end
          StPar: begin
            if (sample) begin
              ovs_cnt_q <= '0;
              par_q     <= bus.sin;
              perr_q    <= (bus.sin != exp_par);
              state_q   <= StStop;
            end else begin
              ovs_cnt_q <= ovs_cnt_q + 1'b1;
            end
          end
          StStop: begin
            if (sample) begin
              ovs_cnt_q    <= '0;
              dout_q       <= data_q;
              pe_q         <= pen_q & perr_q;
              fe_q         <= ~bus.sin;
              bi_q         <= (data_q == '0) & (~pen_q | ~par_q) & ~bus.sin;
              rxfinished_q <= 1'b1;
              // A low stop bit means a held break; wait for the line to recover.
              state_q      <= bus.sin ? StIdle : StMwait;
            end else begin
              ovs_cnt_q <= ovs_cnt_q + 1'b1;
            end
          end
          StMwait: begin
            if (bus.sin) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.pe         = pe_q;
  assign bus.fe         = fe_q;
  assign bus.bi         = bi_q;
  assign bus.rxfinished = rxfinished_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: directed frames plus randomized frames, each compared
// against a frame-level model of the expected word and status.
module tb_uart_rx_deframer;
  localparam int unsigned OVS = 16;
  localparam int unsigned DW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_deframer_if #(.DWIDTH(DW)) bus ();

  uart_rx_deframer #(.OVS(OVS), .DWIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int div = 1;
  int strobes = 0;
  logic prev_rf = 1'b0;
  logic [DW-1:0] last_dout = '0;
  logic last_pe = 1'b0, last_fe = 1'b0, last_bi = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // rxclk enable: one pulse every div cycles, updated just after the rising edge.
  initial begin
    int cnt;
    cnt = 0;
    bus.rxclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rxclk = (cnt == 0);
      cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
    end
  end

  // Strobe monitor: counts strobes, captures status, checks strobe width.
  always @(negedge clk) begin
    if (bus.rxfinished) begin
      strobes++;
      check_eq("strobe_width", {31'd0, prev_rf}, 32'd0);
      last_dout = bus.dout;
      last_pe   = bus.pe;
      last_fe   = bus.fe;
      last_bi   = bus.bi;
    end
    prev_rf = bus.rxfinished;
  end

  // Waits for n rxclk-enabled edges, then returns just after the rxclk update.
  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (bus.rxclk) c++;
    end
    #2;
  endtask

  task automatic hold(input logic v, input int n);
    bus.sin = v;
    wait_ticks(n);
  endtask

  // Expected {dout, pe, fe, bi} for a frame, straight from the line rules.
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w, input logic p,
                                        input logic e, input logic s, input logic pbit,
                                        input logic stop);
    int n;
    logic [7:0] mask, m;
    logic ep, pe, fe, bi;
    n    = 5 + int'(w);
    mask = 8'((1 << n) - 1);
    m    = d & mask;
    if (s) ep = ~e;
    else if (e) ep = ^m;
    else ep = ~^m;
    pe = p & (pbit != ep);
    fe = ~stop;
    bi = (m == 8'd0) & (~p | ~pbit) & ~stop;
    return {m, pe, fe, bi};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                            input logic e, input logic s, input logic pbit, input logic stop,
                            input logic scramble, input string tag);
    int s0;
    logic [10:0] exp;
    bus.wls = w;
    bus.pen = p;
    bus.eps = e;
    bus.sp  = s;
    s0 = strobes;
    hold(1'b0, OVS);
    for (int i = 0; i < 5 + int'(w); i++) begin
      hold(d[i], OVS);
      if (i == 0 && scramble) begin
        // Config is latched at the start bit; later changes must not matter.
        bus.wls = 2'($urandom_range(0, 3));
        bus.pen = 1'($urandom_range(0, 1));
        bus.eps = 1'($urandom_range(0, 1));
        bus.sp  = 1'($urandom_range(0, 1));
      end
    end
    if (p) hold(pbit, OVS);
    hold(stop, OVS);
    hold(1'b1, 2 * OVS);
    exp = model(d, w, p, e, s, pbit, stop);
    check_eq({tag, "_strobes"}, 32'(strobes - s0), 32'd1);
    check_eq({tag, "_dout"}, {24'd0, last_dout}, {24'd0, exp[10:3]});
    check_eq({tag, "_pe"}, {31'd0, last_pe}, {31'd0, exp[2]});
    check_eq({tag, "_fe"}, {31'd0, last_fe}, {31'd0, exp[1]});
    check_eq({tag, "_bi"}, {31'd0, last_bi}, {31'd0, exp[0]});
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_dout"}, {24'd0, bus.dout}, 32'd0);
    check_eq({tag, "_pe"}, {31'd0, bus.pe}, 32'd0);
    check_eq({tag, "_fe"}, {31'd0, bus.fe}, 32'd0);
    check_eq({tag, "_bi"}, {31'd0, bus.bi}, 32'd0);
  endtask

  initial begin
    int s0;
    logic [7:0] d;
    bus.sin   = 1'b1;
    bus.clear = 1'b0;
    bus.wls   = 2'b11;
    bus.pen   = 1'b0;
    bus.eps   = 1'b0;
    bus.sp    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    check_eq("reset_rxfinished", {31'd0, bus.rxfinished}, 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "8n1_a5");
    // 5E1, good and bad parity
    send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "5e1_ok");
    send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "5e1_bad");
    // 7-bit stick parity (expected parity bit 0)
    send_frame(8'hD5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "7s_p1");
    send_frame(8'hD5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "7s_p0");

    // Start glitch
    s0 = strobes;
    hold(1'b0, 4);
    hold(1'b1, 3 * OVS);
    check_eq("glitch_strobes", 32'(strobes - s0), 32'd0);

    // Framing error
    bus.wls = 2'b11;
    send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fe_55");

    // Held break
    bus.wls = 2'b11;
    bus.pen = 1'b0;
    s0 = strobes;
    hold(1'b0, 30 * OVS);
    check_eq("brk_strobes", 32'(strobes - s0), 32'd1);
    check_eq("brk_dout", {24'd0, last_dout}, 32'd0);
    check_eq("brk_fe", {31'd0, last_fe}, 32'd1);
    check_eq("brk_bi", {31'd0, last_bi}, 32'd1);
    hold(1'b1, 2 * OVS);
    check_eq("brk_after_strobes", 32'(strobes - s0), 32'd1);
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_brk_3c");

    // Clear mid-DATA
    s0 = strobes;
    hold(1'b0, OVS);
    hold(1'b1, OVS);
    hold(1'b0, OVS);
    hold(1'b1, OVS / 4);
    bus.clear = 1'b1;
    @(posedge clk);
    #2;
    bus.clear = 1'b0;
    hold(1'b1, 2 * OVS);
    check_eq("clear_strobes", 32'(strobes - s0), 32'd0);
    check_outputs_zero("clear");

    // Reset mid-PAR (load nonzero outputs first)
    send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst_81");
    bus.pen = 1'b1;
    bus.eps = 1'b1;
    bus.sp  = 1'b0;
    s0 = strobes;
    hold(1'b0, OVS);
    for (int i = 0; i < 8; i++) hold(1'b1, OVS);
    hold(1'b1, OVS / 4);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    hold(1'b1, 2 * OVS);
    check_eq("rst_strobes", 32'(strobes - s0), 32'd0);
    check_outputs_zero("rst");
    send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst_ff");

    // Randomized frames, varying rxclk rate
    for (int k = 0; k < 24; k++) begin
      div = int'($urandom_range(1, 3));
      wait_ticks(2);
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), 1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
